// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_prefetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE  = 2'd0;
  localparam fetch_state_t S_FETCH = 2'd1;
  localparam fetch_state_t S_STALL = 2'd2;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Fetch unit bus bundle: instruction-memory port, redirect input and decode-side stream.
interface ifetch_prefetch_if;
  import ifetch_prefetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/ifetch_prefetch_sync_fifo.sv
// Synchronous FIFO with flush; head is read straight from registered storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is accepted only when a pop frees the slot that cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential fetch with credit-limited requests,
// in-order response tracking, prefetch buffering and redirect squashing.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               reset,
  ifetch_prefetch_if.master  bus
);

  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W  = FCNT_W + 1;
  localparam int unsigned ENT_W  = $bits(fetch_entry_t);

  fetch_state_t    state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] discard_q, discard_d;

  logic             grant, rsp, redirect, credit_d;
  logic             pf_push, pf_pop, pf_full, pf_empty;
  logic [FCNT_W-1:0] pf_count, pf_count_nxt;
  fetch_entry_t     pf_in, pf_head;
  logic [XLEN-1:0]  pcq_head;
  logic [OUT_W-1:0] pcq_count;
  logic             pcq_full, pcq_empty;

  // Datapath: handshakes, counters and the credit outlook for the next cycle.
  always_comb begin
    grant         = req_q && bus.imem_gnt;
    rsp           = bus.imem_rvalid && !pcq_empty;
    redirect      = bus.redirect_valid;
    pf_pop        = !pf_empty && bus.instr_ready;
    pf_push       = rsp && (discard_q == '0) && !redirect;
    pf_in.instr   = bus.imem_rdata;
    pf_in.pc      = pcq_head;
    outstanding_d = outstanding_q + OUT_W'(grant) - OUT_W'(rsp);

    discard_d = discard_q;
    if (redirect) begin
      discard_d = outstanding_d;
    end else if (rsp && (discard_q != '0)) begin
      discard_d = discard_q - OUT_W'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = pc_align(bus.redirect_pc);
    end else if (grant) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    pf_count_nxt = redirect ? '0 : pf_count + FCNT_W'(pf_push) - FCNT_W'(pf_pop);
    credit_d     = (outstanding_d < OUT_W'(MAX_OUTSTANDING)) &&
                   ((SUM_W'(outstanding_d) + SUM_W'(pf_count_nxt)) < SUM_W'(FIFO_DEPTH));
  end

  // Request is registered, so it is derived from next-cycle state and credit.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (!credit_d) state_d = S_STALL;
      S_STALL: if (credit_d) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      state_d = S_FETCH;
    end
    req_d = (state_d == S_FETCH) && credit_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Addresses of granted requests, consumed in order as responses return.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk   (clk),
    .rst_n (reset),
    .push  (grant),
    .pop   (rsp),
    .flush (1'b0),
    .wdata (fetch_pc_q),
    .rdata (pcq_head),
    .count (pcq_count),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk   (clk),
    .rst_n (reset),
    .push  (pf_push),
    .pop   (pf_pop),
    .flush (redirect),
    .wdata (pf_in),
    .rdata (pf_head),
    .count (pf_count),
    .full  (pf_full),
    .empty (pf_empty)
  );

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = !pf_empty;
  assign bus.instr       = pf_head.instr;
  assign bus.instr_pc    = pf_head.pc;

  a_rvalid_has_request: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_rvalid |-> (outstanding_q != '0));
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    grant |-> !pcq_full);
  a_pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (!reset)
    pcq_count == outstanding_q);
  a_prefetch_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    pf_push |-> (!pf_full || pf_pop));

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomized bench for ifetch_prefetch: the bench plays instruction memory and
// consumer, and predicts the delivered stream with queues of addresses.
module tb_ifetch_prefetch;
  import ifetch_prefetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ifetch_prefetch_if bus ();

  ifetch_prefetch #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem_q[$];     // granted, unreturned addresses (includes stale ones)
  int          mem_cyc[$];   // cycle of each grant
  logic [31:0] fq[$];        // addresses the consumer should see, in order
  logic [31:0] gnt_pc;
  int          stale;
  int          cyc;
  int          grants;
  int          pops;
  int          first_valid;
  bit          dead;
  bit          redir_prev;
  bit          force_rd;
  logic [31:0] force_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge: check outputs, drive inputs, advance model.
  task automatic cycle(input int pg, input int pv, input int pr, input int pd);
    bit          was_dead, g, v, p, d;
    logic [31:0] a, rpc;

    check("instr_valid", 32'(bus.instr_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      check("instr_pc", bus.instr_pc, fq[0]);
      check("instr", bus.instr, word_of(fq[0]));
    end
    check("imem_req", 32'(bus.imem_req),
          32'(!dead && (mem_q.size() < 2) && (mem_q.size() + fq.size() < 4)));
    if (bus.imem_req) check("imem_addr", bus.imem_addr, gnt_pc);
    if (redir_prev) check("valid_after_redirect", 32'(bus.instr_valid), 32'(0));
    if (bus.instr_valid && first_valid < 0) first_valid = cyc;

    was_dead   = dead;
    dead       = 1'b0;
    bus.imem_gnt = int'($urandom % 100) < pg;
    v = 1'b0;
    if (mem_q.size() != 0) begin
      if (mem_cyc[0] < cyc) v = int'($urandom % 100) < pv;
    end
    bus.imem_rvalid = v;
    bus.imem_rdata  = v ? word_of(mem_q[0]) : $urandom;
    bus.instr_ready = int'($urandom % 100) < pr;
    rpc = $urandom;
    d   = !was_dead && (int'($urandom % 100) < pd);
    if (force_rd) begin
      d        = 1'b1;
      rpc      = force_pc;
      force_rd = 1'b0;
    end
    bus.redirect_valid = d;
    bus.redirect_pc    = rpc;

    g = bus.imem_req && bus.imem_gnt;
    p = bus.instr_valid && bus.instr_ready;
    if (p && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
    if (v) begin
      a = mem_q.pop_front();
      void'(mem_cyc.pop_front());
      if (stale > 0) stale--;
      else if (!d) fq.push_back(a);
    end
    if (g) begin
      mem_q.push_back(gnt_pc);
      mem_cyc.push_back(cyc);
      gnt_pc = gnt_pc + 32'd4;
      grants++;
    end
    if (d) begin
      fq.delete();
      stale  = mem_q.size();
      gnt_pc = {rpc[31:2], 2'b00};
    end
    redir_prev = d;
    cyc++;
    @(negedge clk);
  endtask

  // Reset (optionally asynchronously mid-cycle); checks outputs clear without a clock edge.
  task automatic do_reset(input bit mid);
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    if (mid) #2;
    reset = 1'b0;
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'(0));
    check("rst_instr_valid", 32'(bus.instr_valid), 32'(0));
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    check("rst_imem_addr", bus.imem_addr, RST_PC);
    mem_q.delete();
    mem_cyc.delete();
    fq.delete();
    gnt_pc = RST_PC;
    stale  = 0;
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b1;
    dead        = 1'b1;
    cyc         = 0;
    grants      = 0;
    pops        = 0;
    first_valid = -1;
    redir_prev  = 1'b0;
    force_rd    = 1'b0;
  endtask

  initial begin
    // Full-rate streaming: first valid three cycles after release.
    do_reset(1'b0);
    repeat (12) cycle(100, 100, 100, 0);
    check("first_valid_latency", 32'(first_valid), 32'd3);

    // Consumer stalled: four grants fill the pipeline, then requests stop and later resume.
    do_reset(1'b0);
    repeat (12) cycle(100, 100, 0, 0);
    check("grants_ready_low", 32'(grants), 32'd4);
    repeat (12) cycle(100, 100, 100, 0);
    check("req_resumed", 32'(grants > 4), 32'd1);
    check("pops_after_stall", 32'(pops >= 4), 32'd1);

    // Address held across ungranted requests.
    do_reset(1'b0);
    cycle(100, 100, 100, 0);
    cycle(100, 100, 100, 0);
    repeat (3) cycle(0, 100, 100, 0);
    check("addr_hold", bus.imem_addr, 32'h4);
    cycle(100, 100, 100, 0);
    check("addr_after_grant", bus.imem_addr, 32'h8);

    // Redirect with two requests in flight, then an unaligned redirect target.
    do_reset(1'b0);
    cycle(100, 0, 100, 0);
    cycle(100, 0, 100, 0);
    cycle(100, 0, 100, 0);
    force_rd = 1'b1; force_pc = 32'h0000_0100;
    cycle(0, 0, 100, 0);
    repeat (10) cycle(100, 100, 100, 0);
    force_rd = 1'b1; force_pc = 32'h0000_0103;
    cycle(100, 100, 100, 0);
    check("aligned_redirect_addr", bus.imem_addr, 32'h0000_0100);
    repeat (10) cycle(100, 100, 100, 0);

    // Address wrap at the top of the space.
    force_rd = 1'b1; force_pc = 32'hFFFF_FFF5;
    cycle(100, 100, 100, 0);
    repeat (12) cycle(100, 60, 70, 0);

    // Random traffic with redirects under varying bus and consumer pressure.
    for (int ph = 0; ph < 12; ph++) begin
      int pg, pv, pr;
      pg = int'($urandom_range(100, 20));
      pv = int'($urandom_range(100, 20));
      pr = int'($urandom_range(100, 10));
      repeat (200) cycle(pg, pv, pr, 4);
    end

    // Asynchronous reset with the prefetch buffer full; fetch restarts at the reset PC.
    repeat (12) cycle(100, 100, 0, 0);
    check("fifo_full_before_reset", 32'(bus.instr_valid), 32'd1);
    do_reset(1'b1);
    repeat (20) cycle(100, 100, 100, 0);
    check("restart_grants", 32'(grants > 0), 32'd1);
    repeat (300) cycle(70, 70, 70, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
